// File: rtl/pid_controller.sv
// pid_controller: time-multiplexed PID speed loop producing a saturated PWM duty word.
// Define PID_ANTIWINDUP_EN to clamp the integrator at +/-INT_LIMIT instead of wrapping.
module pid_controller #(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_WIDTH = 8,
   parameter int INT_WIDTH = 20,
`ifdef PID_ANTIWINDUP_EN
   parameter int INT_LIMIT = 65535,
`endif
   parameter int FRAC_BITS = 4
) (
   input logic clk,
   input logic reset,
   input logic sample_valid,
   input logic [DATA_WIDTH-1:0] period_speed,
   input logic [DATA_WIDTH-1:0] setpoint_period,
   input logic tuning_done,
   input logic [7:0] Kp,
   input logic [7:0] Ki,
   input logic [6:0] Kd,
   output logic [OUT_WIDTH-1:0] duty,
   output logic duty_valid,
   output logic busy,
   output logic overrun
);
   localparam int EW = DATA_WIDTH + 1;
   localparam int DW = DATA_WIDTH + 2;
   localparam int MW = INT_WIDTH > DW ? INT_WIDTH : DW;
   localparam int AW = MW + 11;
   typedef enum logic [2:0] {IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM, OUT} state_t;
   state_t state_q;
   logic signed [DATA_WIDTH-1:0] pv_q, sp_q;
   logic tuned_q;
   logic [7:0] kp_q, ki_q;
   logic [6:0] kd_q;
   logic signed [EW-1:0] e_q, e_prev_q, e_d;
   logic signed [DW-1:0] de_q;
   logic signed [INT_WIDTH-1:0] integ_q, integ_d;
   logic signed [AW-1:0] acc_q, u_q;
   logic [7:0] gain;
   logic signed [MW-1:0] mul_x;
   logic signed [MW+8:0] prod;
   logic [OUT_WIDTH-1:0] duty_d;

   assign e_d = EW'(pv_q) - EW'(sp_q);
`ifdef PID_ANTIWINDUP_EN
   localparam logic signed [INT_WIDTH:0] LIM = (INT_WIDTH+1)'(INT_LIMIT);
   logic signed [INT_WIDTH:0] isum;
   assign isum = (INT_WIDTH+1)'(integ_q) + (INT_WIDTH+1)'(e_d);
   assign integ_d = isum > LIM ? INT_WIDTH'(LIM) : isum < -LIM ? INT_WIDTH'(-LIM) : isum[INT_WIDTH-1:0];
`else
   assign integ_d = integ_q + INT_WIDTH'(e_d);
`endif

   // One multiplier shared by the three gain terms; integ_q already holds this sample's value in MUL_I.
   always_comb begin
      gain = state_q == MUL_P ? kp_q : state_q == MUL_I ? ki_q : {1'b0, kd_q};
      mul_x = state_q == MUL_P ? MW'(e_q) : state_q == MUL_I ? MW'(integ_q) : MW'(de_q);
      prod = (MW+9)'($signed({1'b0, gain})) * (MW+9)'(mul_x);
   end

   assign duty_d = u_q[AW-1] ? '0 : |u_q[AW-2:OUT_WIDTH] ? '1 : u_q[OUT_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         duty <= '0;
         duty_valid <= 1'b0;
         busy <= 1'b0;
         overrun <= 1'b0;
         integ_q <= '0;
         e_prev_q <= '0;
         acc_q <= '0;
      end else begin
         duty_valid <= 1'b0;
         overrun <= sample_valid && state_q != IDLE;
         case (state_q)
            IDLE: if (sample_valid) begin
               pv_q <= period_speed;
               sp_q <= setpoint_period;
               tuned_q <= tuning_done;
               kp_q <= tuning_done ? Kp : '0;
               ki_q <= tuning_done ? Ki : '0;
               kd_q <= tuning_done ? Kd : '0;
               busy <= 1'b1;
               state_q <= ERR;
            end
            ERR: begin
               e_q <= e_d;
               de_q <= DW'(e_d) - DW'(e_prev_q);
               e_prev_q <= e_d;
               integ_q <= tuned_q ? integ_d : '0;
               state_q <= MUL_P;
            end
            MUL_P: begin
               acc_q <= AW'(prod);
               state_q <= MUL_I;
            end
            MUL_I: begin
               acc_q <= acc_q + AW'(prod);
               state_q <= MUL_D;
            end
            MUL_D: begin
               acc_q <= acc_q + AW'(prod);
               state_q <= SUM;
            end
            SUM: begin
               u_q <= acc_q >>> FRAC_BITS;
               state_q <= OUT;
            end
            OUT: begin
               duty <= duty_d;
               duty_valid <= 1'b1;
               busy <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
